// File: rtl/spim_txn_arbiter_if.sv
// rtl/spim_txn_arbiter_if.sv - requester-side and SPI-master-side signals of the transaction arbiter
interface spim_txn_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ*DATA_W-1:0] req_data_i;
  logic [NUM_REQ-1:0]        req_last_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic                      spim_valid_o;
  logic [DATA_W-1:0]         spim_data_o;
  logic                      spim_last_o;
  logic                      spim_ready_i;
  logic                      spim_busy_i;
  logic                      spim_abort_o;
  logic [NUM_REQ-1:0]        grant_o;
  logic [ID_W-1:0]           grant_id_o;
  logic                      timeout_o;

  modport master (
    input  req_valid_i, req_data_i, req_last_i, spim_ready_i, spim_busy_i,
    output req_ready_o, spim_valid_o, spim_data_o, spim_last_o, spim_abort_o,
           grant_o, grant_id_o, timeout_o
  );

  modport slave (
    output req_valid_i, req_data_i, req_last_i, spim_ready_i, spim_busy_i,
    input  req_ready_o, spim_valid_o, spim_data_o, spim_last_o, spim_abort_o,
           grant_o, grant_id_o, timeout_o
  );
endinterface

// File: rtl/spim_txn_arbiter.sv
// rtl/spim_txn_arbiter.sv - round-robin transaction arbiter in front of the SPI master TX port
// Optional SPIM_ARB_PRIO_EN: requester 0 wins every idle arbitration and does not move the RR pointer.
module spim_txn_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 32,
  parameter int GAP_CYC     = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input logic                  clk,
  input logic                  rst_n,
  spim_txn_arbiter_if.master   bus
);
  localparam int ID_W = $clog2(NUM_REQ);
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, XFER, DRAIN, GAP} state_t;

  state_t              state;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_id;
  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     rr_next;
  logic [TO_W-1:0]     to_cnt;
  logic [7:0]          gap_cnt;

  logic                in_xfer;
  logic                lane_valid;
  logic                lane_last;
  logic                lane_fire;
  logic                abort;
  logic                pick_vld;
  logic [ID_W-1:0]     pick_id;
  logic [ID_W:0]       sum;

  // Pass-through of the granted lane; only XFER lets words move.
  always_comb begin
    in_xfer    = (state == XFER);
    lane_valid = in_xfer && bus.req_valid_i[grant_id];
    lane_last  = bus.req_last_i[grant_id];
    lane_fire  = lane_valid && bus.spim_ready_i;
    abort      = in_xfer && !bus.req_valid_i[grant_id] && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

    bus.spim_valid_o = lane_valid;
    bus.spim_last_o  = in_xfer && lane_last;
    bus.spim_data_o  = (|grant) ? bus.req_data_i[grant_id*DATA_W +: DATA_W] : '0;
    bus.req_ready_o  = '0;
    if (in_xfer && !abort)
      bus.req_ready_o[grant_id] = bus.spim_ready_i;
    bus.spim_abort_o = abort;
    bus.timeout_o    = abort;
    bus.grant_o      = grant;
    bus.grant_id_o   = grant_id;

    rr_next = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
  end

  // Descending scan so the lane closest to rr_ptr is the last (winning) assignment.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = rr_ptr;
    sum      = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      sum = {1'b0, rr_ptr} + (ID_W+1)'(i);
      if (sum >= (ID_W+1)'(NUM_REQ))
        sum = sum - (ID_W+1)'(NUM_REQ);
      if (bus.req_valid_i[sum[ID_W-1:0]]) begin
        pick_vld = 1'b1;
        pick_id  = sum[ID_W-1:0];
      end
    end
`ifdef SPIM_ARB_PRIO_EN
    if (bus.req_valid_i[0]) begin
      pick_vld = 1'b1;
      pick_id  = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= '0;
      grant_id <= '0;
      rr_ptr   <= '0;
      to_cnt   <= '0;
      gap_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_id;
            grant_id <= pick_id;
            to_cnt   <= '0;
            state    <= XFER;
          end
        end
        XFER: begin
          if (abort || (lane_fire && lane_last)) begin
            to_cnt <= '0;
            state  <= DRAIN;
`ifdef SPIM_ARB_PRIO_EN
            if (grant_id != '0)
              rr_ptr <= rr_next;
`else
            rr_ptr <= rr_next;
`endif
          end else if (lane_fire) begin
            to_cnt <= '0;
          end else if (!lane_valid) begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        DRAIN: begin
          // Chip select must be released before the idle gap starts counting.
          if (!bus.spim_busy_i) begin
            grant <= '0;
            if (GAP_CYC == 0) begin
              state <= IDLE;
            end else begin
              gap_cnt <= 8'(GAP_CYC);
              state   <= GAP;
            end
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt - 8'd1;
          if (gap_cnt <= 8'd1)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
